imem_boot_ctrl: RTL and testbench

//  Boot/load controller for the single-cycle RISC-V system (sccomp). Holds the CPU in reset,

---
 rtl/imem_boot_ctrl.sv | 151 +++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot loader: holds the CPU in reset, streams a length-prefixed image into imem, then releases it.
// Optional trailing XOR checksum byte enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_ctrl #(
  parameter int ADDR_W       = 10,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_BYTES,
    S_WRITE,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERR
  } state_t;

  localparam state_t      RESET_STATE = RUN_ON_RESET ? S_RUN : S_IDLE;
  localparam logic [31:0] MAX_WORDS   = 32'(1) << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
  localparam state_t      LOAD_END    = S_CHK;
`else
  localparam state_t      LOAD_END    = S_RUN;
`endif

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;  // one spare bit so a full image never wraps
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shift_q, shift_d;
  logic [15:0]       cnt_full;
  logic              xfer;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  // Every output is decoded from the registered state, so none of them glitch on rx_valid.
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_HDR0, S_HDR1, S_BYTES: begin rx_ready = 1'b1; busy = 1'b1; end
      S_WRITE:                 busy = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:                   begin rx_ready = 1'b1; busy = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = word_idx_q[ADDR_W-1:0];
  assign imem_wdata = shift_q;
  assign cpu_rstn   = (state_q == S_RUN);
  assign done       = (state_q == S_RUN);
  assign err        = (state_q == S_ERR);
  assign xfer       = rx_valid & rx_ready;
  assign cnt_full   = {rx_data, cnt_q[7:0]};

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: if (start) state_d = S_HDR0;
      S_HDR0: if (xfer) begin
        cnt_d[7:0] = rx_data;
        state_d    = S_HDR1;
      end
      S_HDR1: if (xfer) begin
        cnt_d[15:8] = rx_data;
        if (cnt_full == 16'd0) begin
          state_d = LOAD_END;
        end else if (32'(cnt_full) > MAX_WORDS) begin
          state_d = S_ERR;
        end else begin
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = S_BYTES;
        end
      end
      S_BYTES: if (xfer) begin
        shift_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + (ADDR_W+1)'(1);
        state_d    = (32'(word_idx_q) + 32'd1 == 32'(cnt_q)) ? LOAD_END : S_BYTES;
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: if (xfer) state_d = (rx_data == xor_q) ? S_RUN : S_ERR;
`endif
      default: state_d = RESET_STATE;
    endcase
  end

`ifdef BOOT_CHECKSUM_EN
  // Running XOR over header and payload; cleared whenever a new load is started.
  always_comb begin
    xor_d = xor_q;
    if ((state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR) && start)
      xor_d = 8'h00;
    else if (xfer && (state_q == S_HDR0 || state_q == S_HDR1 || state_q == S_BYTES))
      xor_d = xor_q ^ rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) xor_q <= 8'h00;
    else       xor_q <= xor_d;
  end
`endif

  // NOTE: state flops use non-blocking assignment so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: per-cycle vector table plus stalled, max-size,
// mid-load reset and (with BOOT_CHECKSUM_EN) checksum sequences.
module tb_imem_boot_ctrl;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0, rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, imem_we, cpu_rstn, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  logic              r_rx_ready, r_imem_we, r_cpu_rstn, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .RUN_ON_RESET(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err));

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .RUN_ON_RESET(1'b1)) u_dut_ror (
    .clk(clk), .rstn(rstn), .start(1'b0), .rx_data(8'h00), .rx_valid(1'b0),
    .rx_ready(r_rx_ready), .imem_we(r_imem_we), .imem_addr(r_imem_addr),
    .imem_wdata(r_imem_wdata), .cpu_rstn(r_cpu_rstn), .busy(r_busy), .done(r_done),
    .err(r_err));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Write monitor, sampled mid-cycle.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t wr_log[$];
  wr_t mon_w;
  always @(negedge clk) begin
    if (rstn && imem_we) begin
      mon_w.addr = imem_addr;
      mon_w.data = imem_wdata;
      wr_log.push_back(mon_w);
    end
  end

  typedef struct {
    logic              start, valid;
    logic [7:0]        data;
    logic              rdy, we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              cpu, bsy, dn, er;
  } vec_t;

  function automatic vec_t mk(input logic s, v, input logic [7:0] d, input logic rdy, we,
                              input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                              input logic cpu, bsy, dn, er);
    vec_t t;
    t.start = s; t.valid = v; t.data = d; t.rdy = rdy; t.we = we; t.addr = a; t.wdata = wd;
    t.cpu = cpu; t.bsy = bsy; t.dn = dn; t.er = er;
    return t;
  endfunction

  logic [31:0] img_q[$];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    int tries = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
      tries++;
    end
    rx_valid = 1'b0;
    if (!acc) timeout("send_byte");
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_image(input int gap, input bit corrupt);
    logic [7:0]  x;
    logic [15:0] cnt;
    logic [31:0] w;
    cnt = 16'(img_q.size());
    x = cnt[7:0] ^ cnt[15:8];
    send_byte(cnt[7:0], gap);
    send_byte(cnt[15:8], gap);
    foreach (img_q[i]) begin
      w = img_q[i];
      for (int k = 0; k < 4; k++) begin
        x ^= w[8*k +: 8];
        send_byte(w[8*k +: 8], gap);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(corrupt ? (x ^ 8'h01) : x, gap);
`else
    if (corrupt) x = ~x;
`endif
  endtask

  task automatic wait_end(input int budget);
    int i = 0;
    while (!(done || err) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (!(done || err)) timeout("wait_end");
  endtask

  localparam int NV = 29;
  vec_t tbl[NV];
  int   bad;

  initial begin
    // Full-rate image, RUN ignores bytes, oversize header, empty image, start during BYTES.
    tbl[0]  = mk(0, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 8'h02, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 8'h13, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 8'h05, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 8'h00, 0, 1, 0, 32'h0000_0513, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 8'h93, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 1, 8'h05, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 1, 8'h10, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 8'h00, 0, 1, 1, 32'h0010_0593, 0, 1, 0, 0);
    tbl[13] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[14] = mk(0, 1, 8'hAA, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[15] = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[16] = mk(0, 1, 8'h01, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[17] = mk(0, 1, 8'h04, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[18] = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[19] = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[20] = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[21] = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(0, 1, 8'h01, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[23] = mk(0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[24] = mk(1, 1, 8'h78, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[25] = mk(0, 1, 8'h56, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[26] = mk(0, 1, 8'h34, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[27] = mk(0, 1, 8'h12, 0, 1, 0, 32'h1234_5678, 0, 1, 0, 0);
    tbl[28] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0);

    #22;
    check("rst cpu_rstn", cpu_rstn, 0);
    check("rst done", done, 0);
    check("rst rx_ready", rx_ready, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    check("rst imem_we", imem_we, 0);
    check("rst imem_addr", 32'(imem_addr), 0);
    check("rst imem_wdata", imem_wdata, 0);
    check("ror cpu_rstn", r_cpu_rstn, 1);
    check("ror done", r_done, 1);
    check("ror busy", r_busy, 0);
    check("ror rx_ready", r_rx_ready, 0);
    check("ror err", r_err, 0);
    check("ror imem_we", r_imem_we, 0);
    check("ror imem_addr", 32'(r_imem_addr), 0);
    check("ror imem_wdata", r_imem_wdata, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

`ifndef BOOT_CHECKSUM_EN
    for (int i = 0; i < NV; i++) begin
      start    = tbl[i].start;
      rx_valid = tbl[i].valid;
      rx_data  = tbl[i].data;
      @(posedge clk); #1;
      check($sformatf("v%0d rx_ready", i), rx_ready, tbl[i].rdy);
      check($sformatf("v%0d imem_we", i),  imem_we,  tbl[i].we);
      check($sformatf("v%0d cpu_rstn", i), cpu_rstn, tbl[i].cpu);
      check($sformatf("v%0d busy", i),     busy,     tbl[i].bsy);
      check($sformatf("v%0d done", i),     done,     tbl[i].dn);
      check($sformatf("v%0d err", i),      err,      tbl[i].er);
      if (tbl[i].we) begin
        check($sformatf("v%0d imem_addr", i),  32'(imem_addr), 32'(tbl[i].addr));
        check($sformatf("v%0d imem_wdata", i), imem_wdata,     tbl[i].wdata);
      end
    end
    start    = 1'b0;
    rx_valid = 1'b0;
`endif

    // Stalled stream: three idle cycles between bytes, same writes expected.
    wr_log.delete();
    img_q = '{32'h0000_0513, 32'h0010_0593};
    pulse_start();
    check("stall cpu_rstn after start", cpu_rstn, 0);
    check("stall busy after start", busy, 1);
    send_image(3, 1'b0);
    wait_end(100);
    check("stall done", done, 1);
    check("stall cpu_rstn", cpu_rstn, 1);
    check("stall writes", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("stall w0 addr", 32'(wr_log[0].addr), 0);
      check("stall w0 data", wr_log[0].data, 32'h0000_0513);
      check("stall w1 addr", 32'(wr_log[1].addr), 1);
      check("stall w1 data", wr_log[1].data, 32'h0010_0593);
    end

    // Largest legal image: 2**ADDR_W words, last address must not wrap.
    wr_log.delete();
    img_q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) img_q.push_back(32'hA500_0000 ^ (32'(i) * 32'h0001_0003));
    pulse_start();
    send_image(0, 1'b0);
    wait_end(100);
    check("max done", done, 1);
    check("max err", err, 0);
    check("max writes", wr_log.size(), 1 << ADDR_W);
    bad = 0;
    foreach (wr_log[i])
      if (32'(wr_log[i].addr) != 32'(i) || i >= img_q.size() || wr_log[i].data != img_q[i]) bad++;
    check("max write contents", bad, 0);
    if (wr_log.size() > 0)
      check("max last addr", 32'(wr_log[wr_log.size()-1].addr), (1 << ADDR_W) - 1);

    // Asynchronous reset mid-load returns straight to IDLE, then a fresh load works.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    #2 rstn = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst rx_ready", rx_ready, 0);
    check("midrst cpu_rstn", cpu_rstn, 0);
    check("midrst done", done, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("midrst idle busy", busy, 0);
    wr_log.delete();
    img_q = '{32'hCAFE_F00D};
    pulse_start();
    send_image(1, 1'b0);
    wait_end(100);
    check("recover done", done, 1);
    check("recover writes", wr_log.size(), 1);
    if (wr_log.size() == 1) check("recover data", wr_log[0].data, 32'hCAFE_F00D);

`ifdef BOOT_CHECKSUM_EN
    img_q = '{32'h0000_0513, 32'h0010_0593};
    pulse_start();
    send_image(0, 1'b0);
    wait_end(100);
    check("chk good done", done, 1);
    check("chk good err", err, 0);
    pulse_start();
    send_image(0, 1'b1);
    wait_end(100);
    check("chk bad err", err, 1);
    check("chk bad cpu_rstn", cpu_rstn, 0);
    pulse_start();
    check("chk recover err", err, 0);
    check("chk recover busy", busy, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
